axi2ahb_wr_buffer: RTL

AXI2AHB_WR_BUFFER -- requirements
Module: axi2ahb_wr_buffer

---
 rtl/axi2ahb_wr_buffer_pkg.sv | 24 ++
 rtl/axi2ahb_sync_fifo.sv | 57 +++++
 rtl/axi2ahb_wr_buffer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/axi2ahb_wr_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi2ahb_wr_buffer_pkg
// Brief    : Shared constants and helpers for the AXI-to-AHB write buffer.
// Revision : 1.0
// ============================================================================
package axi2ahb_wr_buffer_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEFAULT_DATA_BITS = 32;
    localparam int DEFAULT_ID_BITS   = 4;
    localparam int DEFAULT_CMD_DEPTH = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi2ahb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axi2ahb_sync_fifo
// Brief    : Show-ahead synchronous FIFO; dout is the head entry, 0 when empty.
// Revision : 1.0
// ============================================================================
module axi2ahb_sync_fifo
    import axi2ahb_wr_buffer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [clog2(DEPTH):0] level
);

    localparam int c_aw = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign level = r_wr_ptr - r_rd_ptr;
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign dout  = empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/axi2ahb_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axi2ahb_wr_buffer
// Brief    : Buffers AXI write bursts for an AHB master and returns B responses.
// Revision : 1.0
// ============================================================================
module axi2ahb_wr_buffer #(
    parameter int         DATA_BITS   = axi2ahb_wr_buffer_pkg::DEFAULT_DATA_BITS,
    parameter int         ID_BITS     = axi2ahb_wr_buffer_pkg::DEFAULT_ID_BITS,
    parameter int         DATA_DEPTH  = 32,
    parameter int         CMD_DEPTH   = axi2ahb_wr_buffer_pkg::DEFAULT_CMD_DEPTH,
    parameter logic [1:0] RESP_SLVERR = axi2ahb_wr_buffer_pkg::RESP_SLVERR
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic [ID_BITS-1:0]                                 WID,
    input  logic [DATA_BITS-1:0]                               WDATA,
    input  logic                                               WLAST,
    input  logic                                               WVALID,
    output logic                                               WREADY,
    output logic [ID_BITS-1:0]                                 BID,
    output logic [1:0]                                         BRESP,
    output logic                                               BVALID,
    input  logic                                               BREADY,
    output logic [DATA_BITS-1:0]                               HWDATA,
    input  logic                                               HREADY,
    input  logic                                               HRESP,
    input  logic                                               cmd_err,
    input  logic                                               wdata_phase,
    input  logic                                               data_last,
    output logic                                               wdata_ready,
    output logic [axi2ahb_wr_buffer_pkg::clog2(DATA_DEPTH):0]  data_level
);

    import axi2ahb_wr_buffer_pkg::*;

    localparam int              c_cw      = clog2(CMD_DEPTH) + 1;
    localparam logic [c_cw-1:0] c_cmd_max = c_cw'(CMD_DEPTH);
    localparam logic [c_cw-1:0] c_one     = c_cw'(1);

    logic                  w_data_empty, w_data_full;
    logic                  w_id_empty, w_id_full;
    logic [c_cw-1:0]       w_id_level;
    logic [ID_BITS-1:0]    w_id_head;
    logic                  w_resp_empty, w_resp_full;
    logic [c_cw-1:0]       w_resp_level;
    logic                  w_beat_push, w_beat_pop, w_ahb_beat;
    logic                  w_axi_last, w_ahb_last_raw, w_ahb_last, w_resp_pop;
    logic                  w_beat_err;
    logic [1:0]            w_resp;
    logic [c_cw-1:0]       r_burst_cnt, r_outstanding;
    logic                  r_err_acc;
    logic                  w_unused;

    assign w_beat_push    = WVALID & WREADY;
    assign w_ahb_beat     = wdata_phase & HREADY;
    assign w_beat_pop     = w_ahb_beat & ~w_data_empty;
    assign w_axi_last     = w_beat_push & WLAST;
    assign w_ahb_last_raw = w_ahb_beat & data_last;
    // A last beat with no burst on record is a protocol violation and is dropped.
    assign w_ahb_last     = w_ahb_last_raw & ~w_id_empty;
    assign w_resp_pop     = BVALID & BREADY;

    assign w_beat_err  = w_ahb_beat & (HRESP | cmd_err | w_data_empty);
    assign w_resp      = (r_err_acc | w_beat_err) ? RESP_SLVERR : RESP_OKAY;

    assign WREADY      = ~w_data_full & (r_outstanding != c_cmd_max);
    assign wdata_ready = (r_burst_cnt != '0);
    assign BVALID      = ~w_resp_empty;
    assign w_unused    = ^{w_id_full, w_id_level, w_resp_full, w_resp_level};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_cnt   <= '0;
            r_outstanding <= '0;
            r_err_acc     <= 1'b0;
        end else begin
            if (w_axi_last && !w_ahb_last)      r_burst_cnt <= r_burst_cnt + c_one;
            else if (w_ahb_last && !w_axi_last) r_burst_cnt <= r_burst_cnt - c_one;

            if (w_axi_last && !w_resp_pop)      r_outstanding <= r_outstanding + c_one;
            else if (w_resp_pop && !w_axi_last) r_outstanding <= r_outstanding - c_one;

            // Clear wins so an error on the last beat never leaks into the next burst.
            if (w_ahb_last_raw)  r_err_acc <= 1'b0;
            else if (w_beat_err) r_err_acc <= 1'b1;
        end
    end

    axi2ahb_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DATA_DEPTH)
    ) u_data_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_beat_push),
        .din   (WDATA),
        .pop   (w_beat_pop),
        .dout  (HWDATA),
        .empty (w_data_empty),
        .full  (w_data_full),
        .level (data_level)
    );

    axi2ahb_sync_fifo #(
        .WIDTH (ID_BITS),
        .DEPTH (CMD_DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_axi_last),
        .din   (WID),
        .pop   (w_ahb_last),
        .dout  (w_id_head),
        .empty (w_id_empty),
        .full  (w_id_full),
        .level (w_id_level)
    );

    axi2ahb_sync_fifo #(
        .WIDTH (2 + ID_BITS),
        .DEPTH (CMD_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_ahb_last),
        .din   ({w_resp, w_id_head}),
        .pop   (w_resp_pop),
        .dout  ({BRESP, BID}),
        .empty (w_resp_empty),
        .full  (w_resp_full),
        .level (w_resp_level)
    );

endmodule
`default_nettype wire
